// File: rtl/kuuga_mem_pkg.sv
// rtl/kuuga_mem_pkg.sv - shared widths, owner tag and address shift for the BRAM arbiter
package kuuga_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BE_W       = 4;
  localparam int BYTE_SHIFT = 2;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/kuuga_bram_arbiter_if.sv
// rtl/kuuga_bram_arbiter_if.sv - single-port BRAM command/read bus
interface kuuga_bram_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  import kuuga_mem_pkg::*;

  logic                  bram_en_o;
  logic [BE_W-1:0]       bram_we_o;
  logic [ADDR_WIDTH-1:0] bram_addr_o;
  logic [WORD_W-1:0]     bram_wrdata_o;
  logic [WORD_W-1:0]     bram_rddata_i;
  logic                  bram_rst_o;

  modport master (
    output bram_en_o, bram_we_o, bram_addr_o, bram_wrdata_o, bram_rst_o,
    input  bram_rddata_i
  );

  modport slave (
    input  bram_en_o, bram_we_o, bram_addr_o, bram_wrdata_o, bram_rst_o,
    output bram_rddata_i
  );

endinterface

// File: rtl/kuuga_bram_arbiter_sat_counter.sv
// rtl/kuuga_bram_arbiter_sat_counter.sv - up counter that sticks at MAX, clear wins over inc
module kuuga_sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/kuuga_bram_arbiter.sv
// rtl/kuuga_bram_arbiter.sv - shares one read-latency-1 BRAM between fetch and data ports
// Data wins ties unless fetch has waited STARVE_LIMIT cycles; responses return on the issuing port.
module kuuga_bram_arbiter
  import kuuga_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  inst_req_i,
  input  logic [31:0]           inst_addr_i,
  output logic                  inst_gnt_o,
  output logic                  inst_rvalid_o,
  output logic [WORD_W-1:0]     inst_rdata_o,

  input  logic                  data_req_i,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [BE_W-1:0]       data_be_i,
  input  logic [WORD_W-1:0]     data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [WORD_W-1:0]     data_rdata_o,

  kuuga_bram_arbiter_if.master  bram,

  output logic [CNT_WIDTH-1:0]  inst_grants_o,
  output logic [CNT_WIDTH-1:0]  data_grants_o,
  output logic [CNT_WIDTH-1:0]  inst_stalls_o
);

  logic       ready_q;
  logic       inflight_vld_q, inflight_vld_d;
  owner_e     inflight_own_q, inflight_own_d;
  logic       inst_gnt, data_gnt;
  logic [7:0] starve_cnt;
  logic       starve_hit;
  logic       inst_stall;
  logic       unused_addr_bits;

  assign starve_hit = (starve_cnt == 8'(STARVE_LIMIT));
  assign inst_stall = inst_req_i & ~inst_gnt;

  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (ready_q) begin
      if (inst_req_i && (!data_req_i || starve_hit)) begin
        inst_gnt = 1'b1;
      end else if (data_req_i) begin
        data_gnt = 1'b1;
      end
    end
  end

  // Write data is forwarded on every grant; only the byte enables gate a write.
  always_comb begin
    bram.bram_en_o     = inst_gnt | data_gnt;
    bram.bram_we_o     = '0;
    bram.bram_addr_o   = '0;
    bram.bram_wrdata_o = '0;
    if (data_gnt) begin
      bram.bram_addr_o   = data_addr_i[ADDR_WIDTH+BYTE_SHIFT-1:BYTE_SHIFT];
      bram.bram_we_o     = data_we_i ? data_be_i : '0;
      bram.bram_wrdata_o = data_wdata_i;
    end else if (inst_gnt) begin
      bram.bram_addr_o   = inst_addr_i[ADDR_WIDTH+BYTE_SHIFT-1:BYTE_SHIFT];
      bram.bram_wrdata_o = data_wdata_i;
    end
  end

  assign bram.bram_rst_o = 1'b0;

  always_comb begin
    inflight_vld_d = inst_gnt | data_gnt;
    inflight_own_d = data_gnt ? OWNER_DATA : OWNER_INST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q        <= 1'b0;
      inflight_vld_q <= 1'b0;
      inflight_own_q <= OWNER_INST;
    end else begin
      ready_q        <= 1'b1;
      inflight_vld_q <= inflight_vld_d;
      inflight_own_q <= inflight_own_d;
    end
  end

  assign inst_gnt_o    = inst_gnt;
  assign data_gnt_o    = data_gnt;
  assign inst_rvalid_o = inflight_vld_q && (inflight_own_q == OWNER_INST);
  assign data_rvalid_o = inflight_vld_q && (inflight_own_q == OWNER_DATA);
  assign inst_rdata_o  = inst_rvalid_o ? bram.bram_rddata_i : '0;
  assign data_rdata_o  = data_rvalid_o ? bram.bram_rddata_i : '0;

  // Byte-offset and above-window address bits are intentionally dropped.
  assign unused_addr_bits = ^{inst_addr_i, data_addr_i};

  kuuga_sat_counter #(.WIDTH(8), .MAX(8'(STARVE_LIMIT))) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inst_stall),
    .clr_i   (~inst_req_i | inst_gnt),
    .count_o (starve_cnt)
  );

  kuuga_sat_counter #(.WIDTH(CNT_WIDTH)) u_inst_grants (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inst_gnt),
    .clr_i   (1'b0),
    .count_o (inst_grants_o)
  );

  kuuga_sat_counter #(.WIDTH(CNT_WIDTH)) u_data_grants (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (data_gnt),
    .clr_i   (1'b0),
    .count_o (data_grants_o)
  );

  kuuga_sat_counter #(.WIDTH(CNT_WIDTH)) u_inst_stalls (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inst_stall),
    .clr_i   (1'b0),
    .count_o (inst_stalls_o)
  );

endmodule

// File: tb/tb_kuuga_bram_arbiter.sv
// tb/tb_kuuga_bram_arbiter.sv - scoreboard bench for kuuga_bram_arbiter
module tb_kuuga_bram_arbiter;

  localparam int AW = 16;
  localparam int SL = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_be = '0;
  logic        inst_gnt, data_gnt, inst_rvalid, data_rvalid;
  logic [31:0] inst_rdata, data_rdata;
  logic [31:0] inst_grants, data_grants, inst_stalls;
  logic        inst_gnt4, data_gnt4, inst_rvalid4, data_rvalid4;
  logic [31:0] inst_rdata4, data_rdata4;
  logic [3:0]  inst_grants4, data_grants4, inst_stalls4;

  kuuga_bram_arbiter_if #(.ADDR_WIDTH(AW)) bif ();
  kuuga_bram_arbiter_if #(.ADDR_WIDTH(AW)) bif4 ();

  kuuga_bram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt),
    .inst_rvalid_o(inst_rvalid), .inst_rdata_o(inst_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .bram(bif),
    .inst_grants_o(inst_grants), .data_grants_o(data_grants), .inst_stalls_o(inst_stalls)
  );

  kuuga_bram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt4),
    .inst_rvalid_o(inst_rvalid4), .inst_rdata_o(inst_rdata4),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt4),
    .data_rvalid_o(data_rvalid4), .data_rdata_o(data_rdata4),
    .bram(bif4),
    .inst_grants_o(inst_grants4), .data_grants_o(data_grants4), .inst_stalls_o(inst_stalls4)
  );

  always #5 clk = ~clk;

  // BRAM: read-first, one cycle latency
  logic [31:0] bram_mem [0:65535];
  logic [31:0] bram_q = '0;
  always @(posedge clk) begin
    if (bif.bram_en_o) begin
      bram_q <= bram_mem[bif.bram_addr_o];
      for (int b = 0; b < 4; b++)
        if (bif.bram_we_o[b]) bram_mem[bif.bram_addr_o][8*b +: 8] <= bif.bram_wrdata_o[8*b +: 8];
    end
  end
  assign bif.bram_rddata_i  = bram_q;
  assign bif4.bram_rddata_i = 32'h0;

  // Reference model state
  logic [31:0] ref_mem [0:65535];
  exp_t        inst_q[$];
  exp_t        data_q[$];
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  int          n_ig = 0, n_dg = 0, n_st = 0, inst_wait = 0;
  bit          ready_m = 1'b0, got_i = 1'b0, got_d = 1'b0;
  logic        s_ig;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_init(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // One request cycle: fetch wins when alone or after SL ungranted cycles, else data wins.
  task automatic model_step();
    logic        eig, edg;
    logic [31:0] a;
    logic [15:0] w;
    logic [3:0]  we;
    exp_t        e;
    eig = ready_m && inst_req && (!data_req || inst_wait >= SL);
    edg = ready_m && data_req && !eig;
    chk("inst_gnt", 32'(inst_gnt), 32'(eig));
    chk("data_gnt", 32'(data_gnt), 32'(edg));
    chk("bram_en", 32'(bif.bram_en_o), 32'(eig | edg));
    chk("bram_rst", 32'(bif.bram_rst_o), 32'h0);
    a  = eig ? inst_addr : data_addr;
    w  = a[17:2];
    we = (edg && data_we) ? data_be : 4'h0;
    chk("bram_we", 32'(bif.bram_we_o), 32'(we));
    if (eig || edg) begin
      chk("bram_addr", 32'(bif.bram_addr_o), 32'(w));
      chk("bram_wrdata", bif.bram_wrdata_o, data_wdata);
      e.due  = cyc + 1;
      e.data = ref_mem[w];
      if (eig) inst_q.push_back(e);
      else data_q.push_back(e);
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[w][8*b +: 8] = data_wdata[8*b +: 8];
    end else begin
      chk("bram_addr_idle", 32'(bif.bram_addr_o), 32'h0);
      chk("bram_wrdata_idle", bif.bram_wrdata_o, 32'h0);
    end
    chk("inst_grants", inst_grants, 32'(n_ig));
    chk("data_grants", data_grants, 32'(n_dg));
    chk("inst_stalls", inst_stalls, 32'(n_st));
    chk("sat_inst_grants", 32'(inst_grants4), 32'(sat15(n_ig)));
    chk("sat_data_grants", 32'(data_grants4), 32'(sat15(n_dg)));
    chk("sat_inst_stalls", 32'(inst_stalls4), 32'(sat15(n_st)));
    s_ig = inst_gnt;
    if (inst_req && !eig) begin
      n_st++;
      inst_wait++;
    end else begin
      inst_wait = 0;
    end
    n_ig += int'(eig);
    n_dg += int'(edg);
    got_i = eig;
    got_d = edg;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_q.size() > 0 && inst_q[0].due == cyc) begin
        mon_e = inst_q.pop_front();
        chk("inst_rvalid", 32'(inst_rvalid), 32'h1);
        chk("inst_rdata", inst_rdata, mon_e.data);
      end else begin
        chk("inst_rvalid_idle", 32'(inst_rvalid), 32'h0);
        chk("inst_rdata_idle", inst_rdata, 32'h0);
      end
      if (data_q.size() > 0 && data_q[0].due == cyc) begin
        mon_e = data_q.pop_front();
        chk("data_rvalid", 32'(data_rvalid), 32'h1);
        chk("data_rdata", data_rdata, mon_e.data);
      end else begin
        chk("data_rvalid_idle", 32'(data_rvalid), 32'h0);
        chk("data_rdata_idle", data_rdata, 32'h0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    ready_m = rst_n;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_we  = 1'b0;
    inst_q.delete();
    data_q.delete();
    n_ig = 0; n_dg = 0; n_st = 0; inst_wait = 0;
    ready_m = 1'b0;
    @(negedge clk);
    chk("rst_inst_gnt", 32'(inst_gnt), 32'h0);
    chk("rst_data_gnt", 32'(data_gnt), 32'h0);
    chk("rst_inst_rvalid", 32'(inst_rvalid), 32'h0);
    chk("rst_data_rvalid", 32'(data_rvalid), 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_bram_en", 32'(bif.bram_en_o), 32'h0);
    chk("rst_bram_we", 32'(bif.bram_we_o), 32'h0);
    chk("rst_bram_addr", 32'(bif.bram_addr_o), 32'h0);
    chk("rst_inst_grants", inst_grants, 32'h0);
    chk("rst_data_grants", data_grants, 32'h0);
    chk("rst_inst_stalls", inst_stalls, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_data(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wd;
  endtask

  task automatic wait_inst();
    int k = 0;
    do begin step(); k++; end while (!got_i && k < 20);
    n_checks++;
    if (!got_i) begin n_errors++; $display("FAIL inst_grant_timeout: no grant in %0d cycles", k); end
    inst_req = 1'b0;
  endtask

  task automatic wait_data();
    int k = 0;
    do begin step(); k++; end while (!got_d && k < 20);
    n_checks++;
    if (!got_d) begin n_errors++; $display("FAIL data_grant_timeout: no grant in %0d cycles", k); end
    data_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    for (int i = 0; i < 65536; i++) begin
      bram_mem[i] = word_init(i);
      ref_mem[i]  = word_init(i);
    end

    // Reset release with a pending data request: no grant in the not-ready cycle
    do_reset();
    set_data(1'b0, 4'h0, 32'h0000_0010, 32'h0);
    wait_data();
    step();

    // Partial write then read-back of the same word
    set_data(1'b1, 4'b0011, 32'h0000_0020, 32'hA5A5_5A5A);
    wait_data();
    set_data(1'b0, 4'h0, 32'h0000_0020, 32'h0);
    wait_data();
    step();

    // Both ports continuously requesting
    do_reset();
    step();
    inst_req  = 1'b1;
    inst_addr = rnd_addr();
    set_data(1'b0, 4'h0, rnd_addr(), $urandom);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      pat = {pat[8:0], s_ig};
      if (got_i) inst_addr = rnd_addr();
      if (got_d) set_data(1'($urandom), 4'($urandom), rnd_addr(), $urandom);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    step();
    chk("starve_pattern", 32'(pat), 32'h021);
    chk("stalls_two_periods", inst_stalls, 32'd8);

    // Alternating back-to-back inst/data/inst
    inst_req = 1'b1; inst_addr = 32'h0000_0104;
    wait_inst();
    set_data(1'b0, 4'h0, 32'h0000_0208, 32'h0);
    wait_data();
    inst_req = 1'b1; inst_addr = 32'h1234_010C;
    wait_inst();
    step();
    step();

    // Reset in the cycle after a data grant drops the pending response
    set_data(1'b0, 4'h0, 32'h0000_0040, 32'h0);
    wait_data();
    do_reset();
    step();
    step();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if (!inst_req || got_i) begin
        inst_req  = ($urandom_range(0, 3) != 0);
        inst_addr = rnd_addr();
      end
      if (!data_req || got_d) begin
        data_req = ($urandom_range(0, 3) != 0);
        set_data(1'($urandom), 4'($urandom), rnd_addr(), $urandom);
        data_req = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    for (int i = 0; i < 3; i++) step();

    chk("sat_inst_grants_final", 32'(inst_grants4), 32'd15);
    chk("inst_q_drained", 32'(inst_q.size()), 32'h0);
    chk("data_q_drained", 32'(data_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kuuga_bram_arbiter.md
# kuuga_bram_arbiter

Shares one single-port, read-latency-1 word-addressed BRAM between the core's instruction-fetch port and data port. It arbitrates with data priority and a bounded starvation guard for fetch. It converts byte addresses to word addresses and returns each response on the port that issued it. It sits between the core's memory ports and a single memory instance, replacing the split instruction/data memory arrangement when one memory must serve both.

## Interface
- ADDR_WIDTH, 16: BRAM word-address width.
- STARVE_LIMIT, 4: consecutive ungranted instruction-request cycles after which fetch wins one arbitration; range 1..255.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic and the BRAM.
- rst_n  in  1  asynchronous, active-low reset.
- inst_req_i / data_req_i  in  1  request valid; held until granted.
- inst_addr_i / data_addr_i  in  32  byte address.
- inst_gnt_o / data_gnt_o  out  1  request accepted this cycle.
- inst_rvalid_o / data_rvalid_o  out  1  response valid.
- inst_rdata_o / data_rdata_o  out  32  response data.
- data_we_i  in  1  write request (fetch never writes).
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  4  byte write enables.
- bram_addr_o  out  ADDR_WIDTH  word address.
- bram_wrdata_o  out  32  write data.
- bram_rddata_i  in  32  BRAM read data, valid the cycle after en.
- bram_rst_o  out  1  tied 0.
- inst_grants_o, data_grants_o, inst_stalls_o  out  CNT_WIDTH  saturating statistics.

## Operation
- Ready flag: cleared by reset, set on the first clk edge after rst_n deasserts. While it is 0, both gnt outputs are 0 and bram_en_o is 0.
- Arbitration is combinational in the request cycle:
  - Data-only request: data granted.
  - Instruction-only request: instruction granted.
  - Both requesting: data granted, unless the starvation counter equals STARVE_LIMIT; then instruction is granted.
- Starvation counter (8 bit):
  - Increments each cycle inst_req_i=1 and inst_gnt_o=0, saturating at STARVE_LIMIT.
  - Clears on an instruction grant or when inst_req_i=0.
- On a grant:
  - bram_en_o=1.
  - bram_addr_o = winning addr[ADDR_WIDTH+1:2]. Bits [1:0] are ignored and upper bits are truncated, so addresses wrap.
  - bram_we_o = data_be_i if data_we_i is set and data wins, else 4'b0.
  - bram_wrdata_o = data_wdata_i.
- In-flight register (valid + owner) is loaded every cycle from the grant decision.
- Every granted transaction, including writes, produces exactly one rvalid on its owner's port.
- rdata is bram_rddata_i passed combinationally. For writes it is the pre-write word (read_first).
- Without an rvalid, rdata outputs hold 0.
- Statistics:
  - inst_grants_o and data_grants_o count grants.
  - inst_stalls_o counts inst_req_i & !inst_gnt_o cycles.
  - All three saturate at all-ones.

## Timing
- Request cycle T with gnt=1: BRAM command is driven in T; rvalid and rdata on that port in T+1.
- Throughput is one transaction per cycle. Back-to-back grants to either or alternating ports are allowed, and each response lands one cycle after its own grant.
- Worst-case instruction wait under continuous data traffic is STARVE_LIMIT cycles; the grant comes in cycle STARVE_LIMIT+1.
- A requester dropping req without gnt is a protocol violation. Behaviour is defined only as "no grant, no response".
- Asynchronous reset mid-transaction:
  - Immediately: rvalid outputs 0, in-flight entry dropped (no response after reset), starvation counter 0, statistics 0, ready 0.
  - No grant occurs in the first cycle after release.
- Reset values: all gnt, rvalid, bram_en_o, bram_we_o are 0; rdata, bram_addr_o, bram_wrdata_o and counters are 0.

## Structure
- Shared package kuuga_mem_pkg holds:
  - the owner enum (OWNER_INST, OWNER_DATA);
  - the 32-bit word/byte-enable widths;
  - the byte-to-word shift constant (2).
- One sub-module, kuuga_sat_counter (parameter WIDTH; inc and clear inputs; saturating). It is instantiated for the three statistics counters and the starvation counter.
- Arbitration decode and the in-flight register stay in the top module.

## Test plan
- Reset release: on the release edge and the next edge, both gnt are 0. Single data read of addr 0x0000_0010 → bram_addr_o=4, rvalid one cycle later with the memory word.
- Data write: be=4'b0011 to 0x20 → bram_we_o=4'b0011 in the grant cycle. A subsequent read of 0x20 returns the updated low half and unchanged high half.
- Both ports requesting continuously with STARVE_LIMIT=4 → data grants in cycles 1–4, instruction in cycle 5, then the pattern repeats. inst_stalls_o=8 after two full periods.
- Alternating back-to-back grants inst/data/inst → three consecutive rvalids, each on the correct port with the correct word.
- Assert rst_n low in the cycle after a data grant → data_rvalid_o never rises and counters read 0.
- Preload inst_grants_o to near all-ones via a forced CNT_WIDTH=4 build, then issue 20 grants → saturates at 15.
